// File: rtl/tick_counter_gen_if.sv
// Control and status bundle for tick_counter_gen.
// The master drives the control strobes and the slave returns the registered count and pulses.
interface tick_counter_gen_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] counter;
  logic             tick;
  logic             flipper;
  logic             wrap;

  modport master (
    output enable, mode, load, load_value,
    input  counter, tick, flipper, wrap
  );

  modport slave (
    input  enable, mode, load, load_value,
    output counter, tick, flipper, wrap
  );
endinterface

// File: rtl/tick_counter_gen.sv
// Divides the clock down to a tick rate and drives a WIDTH-bit counter.
// The counter steps up, steps down, bounces or holds on each tick; flipper toggles and wrap flags the turnarounds.
module tick_counter_gen #(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 1,
  parameter int WIDTH   = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  tick_counter_gen_if.slave   io
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    LAST = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] MAX  = '1;

  if (DIV < 2) begin : g_div_check
    $error("tick_counter_gen: CLK_HZ / TICK_HZ must be at least 2");
  end

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [PW-1:0]    r_presc, w_presc_next;
  logic [WIDTH-1:0] r_count, w_count_next;
  logic             r_tick,  w_tick_next;
  logic             r_flip,  w_flip_next;
  logic             r_wrap,  w_wrap_next;
  dir_t             r_dir,   w_dir_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= '0;
      r_count <= '0;
      r_tick  <= 1'b0;
      r_flip  <= 1'b0;
      r_wrap  <= 1'b0;
      r_dir   <= DIR_UP;
    end else begin
      r_presc <= w_presc_next;
      r_count <= w_count_next;
      r_tick  <= w_tick_next;
      r_flip  <= w_flip_next;
      r_wrap  <= w_wrap_next;
      r_dir   <= w_dir_next;
    end
  end

  always_comb begin
    w_presc_next = r_presc;
    w_count_next = r_count;
    w_tick_next  = 1'b0;
    w_flip_next  = r_flip;
    w_wrap_next  = 1'b0;
    w_dir_next   = r_dir;

    // Load overrides everything, including a tick that would have landed this edge.
    if (io.load) begin
      w_count_next = io.load_value;
      w_presc_next = '0;
      w_dir_next   = DIR_UP;
    end else if (io.enable) begin
      if (r_presc == LAST) begin
        w_presc_next = '0;
        w_tick_next  = 1'b1;
        w_flip_next  = ~r_flip;
        unique case (io.mode)
          2'b00: begin
            w_count_next = r_count + 1'b1;
            w_wrap_next  = (r_count == MAX);
          end
          2'b01: begin
            w_count_next = r_count - 1'b1;
            w_wrap_next  = (r_count == '0);
          end
          2'b10: begin
            if (r_dir == DIR_UP) begin
              if (r_count == MAX) begin
                w_count_next = MAX - 1'b1;
                w_dir_next   = DIR_DOWN;
                w_wrap_next  = 1'b1;
              end else begin
                w_count_next = r_count + 1'b1;
              end
            end else begin
              if (r_count == '0) begin
                w_count_next = WIDTH'(1);
                w_dir_next   = DIR_UP;
                w_wrap_next  = 1'b1;
              end else begin
                w_count_next = r_count - 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end else begin
        w_presc_next = r_presc + 1'b1;
      end
    end
  end

  assign io.counter = r_count;
  assign io.tick    = r_tick;
  assign io.flipper = r_flip;
  assign io.wrap    = r_wrap;
endmodule

// File: tb/tb_tick_counter_gen.sv
// Bench for tick_counter_gen at CLK_HZ=10, TICK_HZ=1, WIDTH=3: directed scenarios then random stimulus,
// every cycle compared against an integer reference model of the counting rules.
module tb_tick_counter_gen;
  localparam int DIVV = 10;
  localparam int MAXV = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  tick_counter_gen_if #(.WIDTH(3)) bus ();

  tick_counter_gen #(.CLK_HZ(10), .TICK_HZ(1), .WIDTH(3)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io      (bus)
  );

  always #5 clk = ~clk;

  // reference model state
  int m_p, m_c, m_dir, m_flip, m_tick, m_wrap;
  int cyc_no = 0;
  int last_tick_cyc = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc_no);
    end
  endtask

  task automatic model_reset();
    m_p = 0; m_c = 0; m_dir = 0; m_flip = 0; m_tick = 0; m_wrap = 0;
  endtask

  // One clock edge of the reference rules, using the inputs the DUT samples on that edge.
  task automatic model_edge();
    m_tick = 0;
    m_wrap = 0;
    if (!rst_n) begin
      model_reset();
    end else if (bus.load) begin
      m_c = int'(bus.load_value);
      m_p = 0;
      m_dir = 0;
    end else if (bus.enable) begin
      if (m_p == DIVV - 1) begin
        m_p = 0;
        m_tick = 1;
        m_flip = 1 - m_flip;
        case (bus.mode)
          2'd0: begin m_wrap = (m_c == MAXV); m_c = (m_c + 1) % (MAXV + 1); end
          2'd1: begin m_wrap = (m_c == 0); m_c = (m_c + MAXV) % (MAXV + 1); end
          2'd2: begin
            if (m_dir == 0 && m_c == MAXV) begin m_c = MAXV - 1; m_dir = 1; m_wrap = 1; end
            else if (m_dir == 1 && m_c == 0) begin m_c = 1; m_dir = 0; m_wrap = 1; end
            else m_c = (m_dir == 0) ? m_c + 1 : m_c - 1;
          end
          default: ;
        endcase
      end else begin
        m_p = m_p + 1;
      end
    end
  endtask

  task automatic check_outputs(input string where);
    chk({where, ".counter"}, 32'(bus.counter), 32'(m_c));
    chk({where, ".tick"},    32'(bus.tick),    32'(m_tick));
    chk({where, ".flipper"}, 32'(bus.flipper), 32'(m_flip));
    chk({where, ".wrap"},    32'(bus.wrap),    32'(m_wrap));
  endtask

  // Advance one clock, update the model, check #1 after the edge.
  task automatic cyc(input string where);
    @(posedge clk);
    model_edge();
    cyc_no++;
    #1;
    check_outputs(where);
    // with enable held high and no load, ticks must be exactly DIV apart
    if (bus.tick === 1'b1) begin
      if (last_tick_cyc >= 0) chk({where, ".tick_gap"}, 32'(cyc_no - last_tick_cyc), 32'(DIVV));
      last_tick_cyc = cyc_no;
    end
  endtask

  task automatic run(input string where, input int n);
    for (int i = 0; i < n; i++) cyc(where);
  endtask

  task automatic do_reset(input logic [1:0] md);
    rst_n = 1'b0;
    bus.enable = 1'b1;
    bus.mode = md;
    bus.load = 1'b0;
    bus.load_value = '0;
    model_reset();
    last_tick_cyc = -1;
    run("reset", 2);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.mode = 2'd0;
    bus.load = 1'b0;
    bus.load_value = '0;
    model_reset();

    // reset state
    do_reset(2'd0);

    // up counting: 1..7, then 0 with wrap
    run("up", 85);

    // down counting from reset: first tick 7 with wrap
    do_reset(2'd1);
    run("down", 95);

    // bounce through both turnarounds
    do_reset(2'd2);
    run("bounce", 155);

    // bounce descending at 4, then switch to up: next tick 5
    do_reset(2'd2);
    run("bounce_to4", 100);
    chk("bounce_at4", 32'(bus.counter), 32'd4);
    bus.mode = 2'd0;
    run("bounce_then_up", 10);
    chk("after_switch_up", 32'(bus.counter), 32'd5);

    // load on the same edge the prescaler would tick
    do_reset(2'd0);
    run("pre_load", 9);
    bus.load = 1'b1;
    bus.load_value = 3'd5;
    cyc("load_edge");
    chk("load_no_tick", 32'(bus.tick), 32'd0);
    bus.load = 1'b0;
    last_tick_cyc = -1;
    run("post_load", 10);
    chk("post_load_val", 32'(bus.counter), 32'd6);

    // freeze at prescaler 4 for 20 cycles, tick 6 cycles after reassertion
    do_reset(2'd0);
    run("pre_freeze", 4);
    bus.enable = 1'b0;
    run("freeze", 20);
    bus.enable = 1'b1;
    last_tick_cyc = -1;
    run("resume", 5);
    chk("resume_not_yet", 32'(bus.tick), 32'd0);
    cyc("resume_tick");
    chk("resume_tick", 32'(bus.tick), 32'd1);

    // async reset mid-period with counter=3, flipper=1
    do_reset(2'd0);
    run("pre_async", 35);
    chk("pre_async_cnt", 32'(bus.counter), 32'd3);
    chk("pre_async_flip", 32'(bus.flipper), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    cyc("async_hold");
    rst_n = 1'b1;
    last_tick_cyc = -1;
    run("after_async", 12);

    // random stimulus against the model
    do_reset(2'($urandom_range(0, 3)));
    for (int i = 0; i < 900; i++) begin
      bus.enable = ($urandom_range(0, 9) != 0);
      bus.load = ($urandom_range(0, 29) == 0);
      bus.load_value = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) bus.mode = 2'($urandom_range(0, 3));
      // gap check only holds across runs of uninterrupted enable without load
      if (!bus.enable || bus.load) last_tick_cyc = -1;
      cyc("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
